// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-bundle bit positions, default widths, zero register.
package pipe_pkg;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned REG_AW         = 5;
    localparam int unsigned MEM_WRITE_BIT  = 0;
    localparam int unsigned MEM_READ_BIT   = 1;
    localparam int unsigned REG_WRITE_BIT  = 0;
    localparam int unsigned MEM_TO_REG_BIT = 1;
    localparam int unsigned ZERO_REG       = 0;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end
endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline register with stall, flush, valid tracking and forwarding qualifier.
// Optional performance counters are built when EX_MEM_PERF_EN is defined.
module ex_mem_pipe #(
    parameter int unsigned DATA_W = pipe_pkg::DATA_W,
    parameter int unsigned REG_AW = pipe_pkg::REG_AW,
    parameter int unsigned MEM_CW = 2,
    parameter int unsigned WB_CW  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall_M,
    input  logic              Flush_M,
    input  logic              Valid_E,
    input  logic [MEM_CW-1:0] MEM_E,
    input  logic [WB_CW-1:0]  WB_E,
    input  logic [DATA_W-1:0] ALUOut_E,
    input  logic [DATA_W-1:0] WriteData_E,
    input  logic [REG_AW-1:0] WriteReg_E,
    output logic              Valid_M,
    output logic [MEM_CW-1:0] MEM_M,
    output logic [WB_CW-1:0]  WB_M,
    output logic [DATA_W-1:0] ALUOut_M,
    output logic [DATA_W-1:0] WriteData_M,
    output logic [REG_AW-1:0] WriteReg_M,
    output logic              FwdEn_M,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  BubbleCnt
);
    import pipe_pkg::*;

    // Priority: reset > flush > stall > load; invalid entries drop their control bits.
    always_ff @(posedge clk) begin
        if (reset || Flush_M) begin
            Valid_M     <= 1'b0;
            MEM_M       <= '0;
            WB_M        <= '0;
            ALUOut_M    <= '0;
            WriteData_M <= '0;
            WriteReg_M  <= '0;
        end else if (!Stall_M) begin
            Valid_M     <= Valid_E;
            MEM_M       <= Valid_E ? MEM_E : '0;
            WB_M        <= Valid_E ? WB_E  : '0;
            ALUOut_M    <= ALUOut_E;
            WriteData_M <= WriteData_E;
            WriteReg_M  <= WriteReg_E;
        end
    end

    assign FwdEn_M = Valid_M & WB_M[REG_WRITE_BIT] & (WriteReg_M != REG_AW'(ZERO_REG));

`ifdef EX_MEM_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = Stall_M & ~Flush_M;
    assign bubble_inc = Flush_M | (~Stall_M & ~Valid_E);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (BubbleCnt)
    );
`else
    assign StallCnt  = '0;
    assign BubbleCnt = '0;
`endif
endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX→MEM pipeline register for the 5-stage core. Beyond plain latching, it supports:
- stall (hold),
- flush (bubble insertion),
- a per-entry valid bit,
- a registered forwarding qualifier for the hazard unit.

It sits between the ALU stage and data-memory stage and carries control bundles, ALU result, store data and destination register.

Parameters:
DATA_W, 32, width of ALUOut and WriteData
REG_AW, 5, register-file address width
MEM_CW, 2, MEM control bundle width; bit0 = MemWrite, bit1 = MemRead
WB_CW, 2, WB control bundle width; bit0 = RegWrite, bit1 = MemtoReg
CNT_W, 16, width of performance counters (used only with EX_MEM_PERF_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
Stall_M  input  1  hold all M-side registers this cycle
Flush_M  input  1  replace incoming entry with a bubble
Valid_E  input  1  EX stage holds a real instruction
MEM_E  input  MEM_CW  MEM control from EX
WB_E  input  WB_CW  WB control from EX
ALUOut_E  input  DATA_W  ALU result
WriteData_E  input  DATA_W  store data (forwarded rt value)
WriteReg_E  input  REG_AW  destination register
Valid_M  output  1  M entry is a real instruction
MEM_M  output  MEM_CW  registered MEM control
WB_M  output  WB_CW  registered WB control
ALUOut_M  output  DATA_W  registered ALU result
WriteData_M  output  DATA_W  registered store data
WriteReg_M  output  REG_AW  registered destination
FwdEn_M  output  1  M entry may forward ALUOut_M to EX
StallCnt  output  CNT_W  stall-cycle count (feature only)
BubbleCnt  output  CNT_W  flushed/invalid-entry count (feature only)

Behaviour:
- Single clock domain; all state updates on posedge clk; latency 1 cycle E→M.
- Reset:
  - Synchronous, active-high.
  - All outputs are 0 the cycle after reset is sampled high, including counters.
  - Reset asserted mid-stall or mid-flush overrides both.
- Per-edge priority: reset > Flush_M > Stall_M > load.
- Flush (Flush_M=1):
  - Valid_M, MEM_M, WB_M, ALUOut_M, WriteData_M and WriteReg_M all load 0.
  - Flush wins over a simultaneous Stall_M; the held entry is discarded.
- Stall (Stall_M=1, Flush_M=0): every M register holds its value. E inputs are ignored; the upstream stage is responsible for holding them.
- Load (neither asserted):
  - Every *_E field is copied to its *_M field, and Valid_M <= Valid_E.
  - If Valid_E=0, MEM_M and WB_M load 0 (bubble), so no side effects leak. Data fields still load.
- WriteData_E is registered into WriteData_M and WriteReg_E into WriteReg_M; the two must never cross.
- FwdEn_M:
  - Combinational from registered state only: FwdEn_M = Valid_M & WB_M[0] & (WriteReg_M != 0).
  - Register 0 never forwards.
- No handshake back-pressure beyond Stall_M; the block never generates stalls itself.
- Widths: all fields pass straight through; no extension or truncation.

Optional Feature:
EX_MEM_PERF_EN
- Defined:
  - StallCnt increments on every non-reset edge with Stall_M=1 and Flush_M=0.
  - BubbleCnt increments on every non-reset edge that loads a bubble, i.e. Flush_M=1, or a load with Valid_E=0.
  - Both counters saturate at all-ones and do not wrap. Reset clears both.
- Undefined: StallCnt and BubbleCnt are tied to 0 and no counter flops exist.
- Port list is identical either way.

Decomposition:
- Shared package pipe_pkg holds:
  - MEM/WB control bit-index constants (MEM_WRITE_BIT=0, MEM_READ_BIT=1, REG_WRITE_BIT=0, MEM_TO_REG_BIT=1),
  - default widths DATA_W/REG_AW,
  - the ZERO_REG constant.
- One natural sub-module: sat_counter (parametrised CNT_W, synchronous reset, inc enable, saturate), instantiated twice under EX_MEM_PERF_EN.

Test Plan:
1. Reset, then load:
   - Stimulus: reset=1 for 2 cycles, then load Valid_E=1, WB_E=2'b01, WriteReg_E=5, ALUOut_E=0x1234, WriteData_E=0xBEEF.
   - Response: all outputs 0 during reset; next cycle ALUOut_M=0x1234, WriteData_M=0xBEEF, WriteReg_M=5, FwdEn_M=1.
2. Stall hold:
   - Stimulus: M holds ALUOut=0xA; Stall_M=1 for 3 cycles while E changes to 0xB, 0xC, 0xD.
   - Response: ALUOut_M stays 0xA all 3 cycles; StallCnt=3 with the feature enabled.
3. Flush over stall:
   - Stimulus: Stall_M=1 and Flush_M=1 together with M valid.
   - Response: next cycle Valid_M=0, MEM_M=0, WB_M=0, FwdEn_M=0; BubbleCnt increments by 1.
4. Invalid-entry squash:
   - Stimulus: Valid_E=0 with MEM_E=2'b01, WB_E=2'b01.
   - Response: MEM_M=0, WB_M=0, Valid_M=0, no memory write issued.
5. Register-zero forward block:
   - Stimulus: valid load with WB_E[0]=1 and WriteReg_E=0.
   - Response: FwdEn_M=0.
6. Counter saturation:
   - Stimulus: with CNT_W=4 and EX_MEM_PERF_EN, hold Stall_M=1 for 20 cycles.
   - Response: StallCnt=15 and holds there; reset mid-stall returns it to 0 on the next cycle.
